// File: rtl/idu_pkg.sv
// Shared decode definitions for the buffered decode stage: decode-info bus layout,
// well-known system instruction words and the decoded FIFO record.
package idu_pkg;

   // Instruction-group code held in the low bits of the decode-info bus; zero means illegal.
   typedef enum logic [2:0] {
      DECINFO_GRP_NONE   = 3'd0,
      DECINFO_GRP_ALU    = 3'd1,
      DECINFO_GRP_BJP    = 3'd2,
      DECINFO_GRP_MULDIV = 3'd3,
      DECINFO_GRP_LSU    = 3'd4,
      DECINFO_GRP_CSR    = 3'd5,
      DECINFO_GRP_SYS    = 3'd6
   } decinfo_grp_e;

   localparam int DECINFO_GRP_LSB      = 0;
   localparam int DECINFO_GRP_WIDTH    = 3;
   localparam int DECINFO_OP2IMM_BIT   = 3;
   localparam int DECINFO_FUNCT3_LSB   = 4;
   localparam int DECINFO_FUNCT3_WIDTH = 3;
   localparam int DECINFO_ALT_BIT      = 7;
   localparam int DECINFO_LUI_BIT      = 8;
   localparam int DECINFO_AUIPC_BIT    = 9;
   localparam int DECINFO_WIDTH        = 10;

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

   localparam logic [31:0] INST_NOP    = 32'h0000_0013;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;
   localparam logic [31:0] INST_DRET   = 32'h7b20_0073;

   typedef struct packed {
      logic [31:0]              inst;
      logic [31:0]              pc;
      logic [31:0]              imm;
      logic [DECINFO_WIDTH-1:0] dec_info;
      logic [4:0]               rs1;
      logic [4:0]               rs2;
      logic [4:0]               rd;
      logic                     rd_we;
      logic                     illegal;
      logic                     is_long;
   } dec_entry_t;

   function automatic logic [DECINFO_WIDTH-1:0] mk_decinfo(
      input decinfo_grp_e grp,
      input logic         op2imm,
      input logic [2:0]   funct3,
      input logic         alt,
      input logic         lui,
      input logic         auipc
   );
      return {auipc, lui, alt, funct3, op2imm, grp};
   endfunction

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32IM decoder: one instruction word in, one FIFO record out.
// Register fields are zeroed when the format does not use them.
module idu_dec
   import idu_pkg::*;
#(
   parameter bit SB_LONG = 1'b1
) (
   input  logic [31:0] inst_i,
   input  logic [31:0] pc_i,
   output dec_entry_t  entry_o
);

   logic [6:0]   opcode;
   logic [2:0]   funct3;
   logic [6:0]   funct7;
   decinfo_grp_e grp;
   logic         op2imm;
   logic         alt;
   logic         lui;
   logic         auipc;
   logic         use_rs1;
   logic         use_rs2;
   logic         use_rd;
   logic         long_op;
   logic [31:0]  imm;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      grp     = DECINFO_GRP_NONE;
      op2imm  = 1'b0;
      alt     = 1'b0;
      lui     = 1'b0;
      auipc   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      long_op = 1'b0;
      imm     = '0;
      unique case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            grp    = DECINFO_GRP_ALU;
            lui    = (opcode == OPC_LUI);
            auipc  = (opcode == OPC_AUIPC);
            op2imm = 1'b1;
            use_rd = 1'b1;
            imm    = {inst_i[31:12], 12'b0};
         end
         OPC_JAL: begin
            grp    = DECINFO_GRP_BJP;
            use_rd = 1'b1;
            imm    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
         end
         OPC_JALR: if (funct3 == 3'd0) begin
            grp     = DECINFO_GRP_BJP;
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            imm     = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         OPC_BRANCH: if (funct3 != 3'd2 && funct3 != 3'd3) begin
            grp     = DECINFO_GRP_BJP;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
         end
         OPC_LOAD: if (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
            grp     = DECINFO_GRP_LSU;
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            long_op = SB_LONG;
            imm     = {{20{inst_i[31]}}, inst_i[31:20]};
         end
         OPC_STORE: if (funct3 <= 3'd2) begin
            grp     = DECINFO_GRP_LSU;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            imm     = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         end
         OPC_OPIMM: begin
            // Shift-immediates constrain the upper funct7 bits; others are plain I-type.
            if ((funct3 == 3'd1 && funct7 == 7'h00) ||
                (funct3 == 3'd5 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
                (funct3 != 3'd1 && funct3 != 3'd5)) begin
               grp     = DECINFO_GRP_ALU;
               op2imm  = 1'b1;
               alt     = (funct3 == 3'd5) && inst_i[30];
               use_rs1 = 1'b1;
               use_rd  = 1'b1;
               imm     = {{20{inst_i[31]}}, inst_i[31:20]};
            end
         end
         OPC_OP: begin
            if (funct7 == 7'h00 ||
                (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
               grp = DECINFO_GRP_ALU;
               alt = inst_i[30];
            end else if (funct7 == 7'h01) begin
               grp     = DECINFO_GRP_MULDIV;
               long_op = 1'b1;
            end
            if (grp != DECINFO_GRP_NONE) begin
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               use_rd  = 1'b1;
            end
         end
         OPC_MISCMEM: if (funct3 <= 3'd1) begin
            grp = DECINFO_GRP_SYS;
         end
         OPC_SYSTEM: begin
            if (funct3 == 3'd0) begin
               if (inst_i inside {INST_ECALL, INST_EBREAK, INST_MRET, INST_DRET}) begin
                  grp = DECINFO_GRP_SYS;
               end
            end else if (funct3 != 3'd4) begin
               grp     = DECINFO_GRP_CSR;
               op2imm  = funct3[2];
               use_rs1 = ~funct3[2];
               use_rd  = 1'b1;
               imm     = {20'b0, inst_i[31:20]};
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      entry_o      = '0;
      entry_o.inst = inst_i;
      entry_o.pc   = pc_i;
      if (grp == DECINFO_GRP_NONE) begin
         entry_o.illegal = 1'b1;
      end else begin
         entry_o.dec_info = mk_decinfo(grp, op2imm, funct3, alt, lui, auipc);
         entry_o.imm      = imm;
         entry_o.rs1      = use_rs1 ? inst_i[19:15] : 5'd0;
         entry_o.rs2      = use_rs2 ? inst_i[24:20] : 5'd0;
         entry_o.rd       = use_rd  ? inst_i[11:7]  : 5'd0;
         entry_o.rd_we    = use_rd && (inst_i[11:7] != 5'd0);
         entry_o.is_long  = long_op;
      end
   end

endmodule

// File: rtl/idu_pipe.sv
// Buffered decode stage: decode on enqueue into a small FIFO, issue the head to execute,
// and hold issue while a long-latency (load / mul-div) result is still owed to a register.
module idu_pipe
   import idu_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter bit SB_EN   = 1'b1,
   parameter bit SB_LONG = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     inst_valid_i,
   output logic                     inst_ready_o,
   input  logic [31:0]              inst_i,
   input  logic [31:0]              inst_addr_i,
   output logic [4:0]               rs1_raddr_o,
   output logic [4:0]               rs2_raddr_o,
   input  logic [31:0]              rs1_rdata_i,
   input  logic [31:0]              rs2_rdata_i,
   output logic                     issue_valid_o,
   input  logic                     issue_ready_i,
   output logic [31:0]              inst_o,
   output logic [DECINFO_WIDTH-1:0] dec_info_bus_o,
   output logic [31:0]              dec_imm_o,
   output logic [31:0]              dec_pc_o,
   output logic [31:0]              rs1_rdata_o,
   output logic [31:0]              rs2_rdata_o,
   output logic [4:0]               rd_waddr_o,
   output logic                     rd_we_o,
   output logic                     illegal_inst_o,
   input  logic                     wb_valid_i,
   input  logic [4:0]               wb_waddr_i,
   output logic                     stall_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   dec_entry_t       dec_entry;
   dec_entry_t       fifo_q [DEPTH];
   dec_entry_t       head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      pend_q, pend_d;
   logic             head_valid;
   logic             hazard;
   logic             enq;
   logic             deq;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   idu_dec #(.SB_LONG(SB_LONG)) u_dec (
      .inst_i  (inst_i),
      .pc_i    (inst_addr_i),
      .entry_o (dec_entry)
   );

   // Ready depends only on state and reset, never on this cycle's handshakes.
   assign inst_ready_o = ~rst && (count_q != CNT_W'(DEPTH));
   assign head_valid   = (count_q != '0);
   assign head         = fifo_q[rd_ptr_q];
   assign enq          = inst_valid_i && inst_ready_o && ~flush_i;
   assign deq          = issue_valid_o && issue_ready_i;

   // pend_q[0] is held at zero, so unused fields (forced to x0) never raise a hazard.
   assign hazard        = SB_EN && (pend_q[head.rs1] || pend_q[head.rs2] || pend_q[head.rd]);
   assign issue_valid_o = head_valid && ~hazard;
   assign stall_o       = head_valid && hazard;

   // NOTE: payload storage has no reset; count_q alone says which slots are meaningful.
   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_q[wr_ptr_q] <= dec_entry;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   // A writeback clear and an issue set on the same register: the new owner wins.
   always_comb begin
      pend_d = pend_q;
      if (wb_valid_i) pend_d[wb_waddr_i] = 1'b0;
      if (deq && head.rd_we && head.is_long) pend_d[head.rd] = 1'b1;
      pend_d[0] = 1'b0;
      if (!SB_EN) pend_d = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pend_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   always_comb begin
      rs1_raddr_o    = '0;
      rs2_raddr_o    = '0;
      inst_o         = '0;
      dec_info_bus_o = '0;
      dec_imm_o      = '0;
      dec_pc_o       = '0;
      rs1_rdata_o    = '0;
      rs2_rdata_o    = '0;
      rd_waddr_o     = '0;
      rd_we_o        = 1'b0;
      illegal_inst_o = 1'b0;
      if (head_valid) begin
         rs1_raddr_o    = head.rs1;
         rs2_raddr_o    = head.rs2;
         inst_o         = head.inst;
         dec_info_bus_o = head.dec_info;
         dec_imm_o      = head.imm;
         dec_pc_o       = head.pc;
         rs1_rdata_o    = rs1_rdata_i;
         rs2_rdata_o    = rs2_rdata_i;
         rd_waddr_o     = head.rd;
         rd_we_o        = head.rd_we;
         illegal_inst_o = head.illegal;
      end
   end

endmodule

// File: tb/tb_idu_pipe.sv
// Self-checking bench for idu_pipe: scoreboard of expected issue records plus directed
// checks on handshake, hazard, flush and reset behaviour.
module tb_idu_pipe;
   import idu_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     flush_i;
   logic                     inst_valid_i;
   logic                     inst_ready_o;
   logic [31:0]              inst_i;
   logic [31:0]              inst_addr_i;
   logic [4:0]               rs1_raddr_o;
   logic [4:0]               rs2_raddr_o;
   logic [31:0]              rs1_rdata_i;
   logic [31:0]              rs2_rdata_i;
   logic                     issue_valid_o;
   logic                     issue_ready_i;
   logic [31:0]              inst_o;
   logic [DECINFO_WIDTH-1:0] dec_info_bus_o;
   logic [31:0]              dec_imm_o;
   logic [31:0]              dec_pc_o;
   logic [31:0]              rs1_rdata_o;
   logic [31:0]              rs2_rdata_o;
   logic [4:0]               rd_waddr_o;
   logic                     rd_we_o;
   logic                     illegal_inst_o;
   logic                     wb_valid_i;
   logic [4:0]               wb_waddr_i;
   logic                     stall_o;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rd_we;
      logic        ill;
      logic [2:0]  grp;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   idu_pipe #(.DEPTH(2), .SB_EN(1'b1), .SB_LONG(1'b1)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush_i        (flush_i),
      .inst_valid_i   (inst_valid_i),
      .inst_ready_o   (inst_ready_o),
      .inst_i         (inst_i),
      .inst_addr_i    (inst_addr_i),
      .rs1_raddr_o    (rs1_raddr_o),
      .rs2_raddr_o    (rs2_raddr_o),
      .rs1_rdata_i    (rs1_rdata_i),
      .rs2_rdata_i    (rs2_rdata_i),
      .issue_valid_o  (issue_valid_o),
      .issue_ready_i  (issue_ready_i),
      .inst_o         (inst_o),
      .dec_info_bus_o (dec_info_bus_o),
      .dec_imm_o      (dec_imm_o),
      .dec_pc_o       (dec_pc_o),
      .rs1_rdata_o    (rs1_rdata_o),
      .rs2_rdata_o    (rs2_rdata_o),
      .rd_waddr_o     (rd_waddr_o),
      .rd_we_o        (rd_we_o),
      .illegal_inst_o (illegal_inst_o),
      .wb_valid_i     (wb_valid_i),
      .wb_waddr_i     (wb_waddr_i),
      .stall_o        (stall_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Hand-decoded reference values for every instruction word the bench drives.
   function automatic exp_t expect_for(input logic [31:0] inst, input logic [31:0] pc);
      exp_t e;
      e.pc = pc; e.inst = inst; e.imm = '0; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
      e.rd_we = 1'b0; e.ill = 1'b0; e.grp = DECINFO_GRP_ALU;
      case (inst)
         32'h0050_0093: begin e.rd = 5'd1;  e.rd_we = 1'b1; e.imm = 32'd5; end
         32'hFFF0_0493: begin e.rd = 5'd9;  e.rd_we = 1'b1; e.imm = 32'hFFFF_FFFF; end
         32'h1234_5537: begin e.rd = 5'd10; e.rd_we = 1'b1; e.imm = 32'h1234_5000; end
         32'h0050_A623: begin e.rs1 = 5'd1; e.rs2 = 5'd5; e.imm = 32'd12; e.grp = DECINFO_GRP_LSU; end
         32'h0220_82B3: begin e.rd = 5'd5; e.rd_we = 1'b1; e.rs1 = 5'd1; e.rs2 = 5'd2;
                              e.grp = DECINFO_GRP_MULDIV; end
         32'h0032_8333: begin e.rd = 5'd6; e.rd_we = 1'b1; e.rs1 = 5'd5; e.rs2 = 5'd3; end
         32'h0081_2383: begin e.rd = 5'd7; e.rd_we = 1'b1; e.rs1 = 5'd2; e.imm = 32'd8;
                              e.grp = DECINFO_GRP_LSU; end
         32'h0013_8413: begin e.rd = 5'd8; e.rd_we = 1'b1; e.rs1 = 5'd7; e.imm = 32'd1; end
         32'h000F_8593: begin e.rd = 5'd11; e.rd_we = 1'b1; e.rs1 = 5'd31; end
         default:       begin e.ill = 1'b1; e.grp = DECINFO_GRP_NONE; end
      endcase
      return e;
   endfunction

   // Scoreboard: compare on issue, push on accepted enqueue, drop everything on flush.
   always @(negedge clk) begin
      if (!rst) begin
         if (issue_valid_o && issue_ready_i) begin
            if (sb.size() == 0) begin
               check("unexpected_issue", dec_pc_o, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("issue_pc",    dec_pc_o,       e.pc);
               check("issue_inst",  inst_o,         e.inst);
               check("issue_imm",   dec_imm_o,      e.imm);
               check("issue_rd",    rd_waddr_o,     e.rd);
               check("issue_rd_we", rd_we_o,        e.rd_we);
               check("issue_rs1",   rs1_raddr_o,    e.rs1);
               check("issue_rs2",   rs2_raddr_o,    e.rs2);
               check("issue_ill",   illegal_inst_o, e.ill);
               check("issue_grp",   dec_info_bus_o[DECINFO_GRP_LSB +: DECINFO_GRP_WIDTH], e.grp);
               if (e.ill) check("decinfo_zero", dec_info_bus_o, '0);
            end
         end
         if (inst_valid_i && inst_ready_o && !flush_i) sb.push_back(expect_for(inst_i, inst_addr_i));
         if (flush_i) sb.delete();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction and hold it until accepted (bounded).
   task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
      int budget;
      budget       = 0;
      inst_valid_i = 1'b1;
      inst_i       = inst;
      inst_addr_i  = pc;
      @(negedge clk);
      while (!inst_ready_o && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      if (!inst_ready_o) check("offer_timeout", 32'd0, 32'd1);
      step();
      inst_valid_i = 1'b0;
   endtask

   // Writeback one register; the waiting instruction must still be held during that cycle.
   task automatic wb_pulse(input logic [4:0] r);
      wb_valid_i = 1'b1;
      wb_waddr_i = r;
      @(negedge clk);
      check("no_bypass_stall", stall_o, 1'b1);
      step();
      wb_valid_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0;
      rs1_rdata_i = 32'hA5A5_0001; rs2_rdata_i = 32'h5A5A_0002;
      issue_ready_i = 1'b0; wb_valid_i = 1'b0; wb_waddr_i = '0;

      // Reset behaviour.
      step();
      @(negedge clk);
      check("rst_ready",     inst_ready_o,  1'b0);
      check("rst_valid",     issue_valid_o, 1'b0);
      check("rst_stall",     stall_o,       1'b0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", inst_ready_o,  1'b1);
      check("post_rst_valid", issue_valid_o, 1'b0);
      check("post_rst_pc",    dec_pc_o,      32'd0);
      check("post_rst_rdata", rs1_rdata_o,   32'd0);
      step();

      // Single instruction, one-cycle latency.
      issue_ready_i = 1'b1;
      offer(32'h0050_0093, 32'h0);
      @(negedge clk);
      check("lat1_valid", issue_valid_o, 1'b1);
      check("lat1_rd",    rd_waddr_o,    32'd1);
      check("lat1_imm",   dec_imm_o,     32'd5);
      check("rs1_pass",   rs1_rdata_o,   32'hA5A5_0001);
      check("rs2_pass",   rs2_rdata_o,   32'h5A5A_0002);
      step();
      repeat (2) step();

      // Fill with execute blocked, third instruction waits; drain in order.
      issue_ready_i = 1'b0;
      inst_valid_i = 1'b1; inst_i = 32'hFFF0_0493; inst_addr_i = 32'h0;
      step();
      inst_i = 32'h1234_5537; inst_addr_i = 32'h4;
      step();
      inst_i = 32'h0050_A623; inst_addr_i = 32'h8;
      @(negedge clk);
      check("full_ready", inst_ready_o,  1'b0);
      check("full_valid", issue_valid_o, 1'b1);
      step();
      issue_ready_i = 1'b1;
      @(negedge clk);
      check("no_enq_full_deq", inst_ready_o, 1'b0);
      step();
      @(negedge clk);
      check("ready_after_deq", inst_ready_o, 1'b1);
      step();
      inst_valid_i = 1'b0;
      repeat (4) step();

      // RAW on a mul-div result: dependent add held until the cycle after writeback.
      offer(32'h0220_82B3, 32'h10);
      offer(32'h0032_8333, 32'h14);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("raw_stall", stall_o,       1'b1);
         check("raw_valid", issue_valid_o, 1'b0);
         step();
      end
      wb_pulse(5'd4);
      @(negedge clk);
      check("other_wb_stall", stall_o, 1'b1);
      step();
      wb_pulse(5'd5);
      @(negedge clk);
      check("raw_release", issue_valid_o, 1'b1);
      check("raw_release_stall", stall_o, 1'b0);
      step();
      repeat (2) step();

      // Flush a full FIFO while fetch is offering.
      issue_ready_i = 1'b0;
      offer(32'h0050_0093, 32'h20);
      offer(32'hFFF0_0493, 32'h24);
      inst_valid_i = 1'b1; inst_i = 32'h1234_5537; inst_addr_i = 32'h28; flush_i = 1'b1;
      step();
      flush_i = 1'b0; inst_valid_i = 1'b0;
      @(negedge clk);
      check("flush_valid", issue_valid_o, 1'b0);
      check("flush_ready", inst_ready_o,  1'b1);
      step();
      // Flush with room: the same-cycle enqueue must be dropped.
      offer(32'h0050_0093, 32'h30);
      inst_valid_i = 1'b1; inst_i = 32'h1234_5537; inst_addr_i = 32'h34; flush_i = 1'b1;
      step();
      flush_i = 1'b0; inst_valid_i = 1'b0; issue_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("flush_drop", issue_valid_o, 1'b0);
         step();
      end

      // Load issue coinciding with writeback of the same register: set wins.
      offer(32'h0081_2383, 32'h40);
      wb_valid_i = 1'b1; wb_waddr_i = 5'd7;
      inst_valid_i = 1'b1; inst_i = 32'h0013_8413; inst_addr_i = 32'h44;
      @(negedge clk);
      check("lw_issue", issue_valid_o, 1'b1);
      step();
      wb_valid_i = 1'b0; inst_valid_i = 1'b0;
      @(negedge clk);
      check("set_wins_stall", stall_o,       1'b1);
      check("set_wins_valid", issue_valid_o, 1'b0);
      step();
      wb_pulse(5'd7);
      @(negedge clk);
      check("lw_release", issue_valid_o, 1'b1);
      step();
      repeat (2) step();

      // Illegal word issues flagged, and leaves no pending bit behind (reads x31 next).
      offer(32'hFFFF_FFFF, 32'h50);
      offer(32'h000F_8593, 32'h54);
      @(negedge clk);
      check("ill_nopend_stall", stall_o,       1'b0);
      check("ill_nopend_valid", issue_valid_o, 1'b1);
      step();
      repeat (3) step();

      @(negedge clk);
      check("sb_drain", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
